bmp_stream_writer: RTL and testbench
====================================

Name: bmp_stream_writer

Overview:
- Hardware end of the image I/O path: takes 24-bit pixels from the output FIFO of the filter pipeline and emits a complete byte stream for a 24-bpp BMP file.
- The stream is a generated 54-byte header, the pixel bytes in file order, and row padding to 4-byte boundaries.
- It feeds a byte-wide FIFO that drains to storage or a UART, replacing software file writing.

Parameters:
- BMP_WIDTH, 720, image width in pixels (1..4095).
- BMP_HEIGHT, 540, image height in rows (1..4095).
- HDR_SIZE, 54, header length in bytes; fixed, used as data offset.
- PPM, 2835, horizontal and vertical resolution field (pixels/metre).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle request to emit one frame; sampled only in IDLE or DONE.
- in_dout  in  24  pixel at head of input FIFO (first-word-fall-through); [23:16] is the first file byte.
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pops the input FIFO.
- out_din  out  8  byte to output FIFO.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  byte write strobe.
- busy  out  1  high in HDR, PIX, PAD.
- done  out  1  high in DONE until next start or reset.

Behaviour:
- Reset (reset=0, async): state=IDLE, all counters 0. in_rd_en=0, out_wr_en=0, out_din=0, busy=0, done=0.
- Derived constants (32-bit unsigned):
  - ROW=BMP_WIDTH*3.
  - PAD=(4-ROW%4)%4.
  - IMG=(ROW+PAD)*BMP_HEIGHT.
  - FSZ=HDR_SIZE+IMG.
- States: IDLE, HDR, PIX, PAD, DONE.
- IDLE/DONE:
  - start=1 moves to HDR and clears hdr_idx, col, row, byte_idx.
  - DONE->HDR deasserts done in the same edge.
- HDR: emits the byte at hdr_idx 0..53. Multi-byte fields are little-endian.
  - 0-1: 0x42 0x4D.
  - 2-5: FSZ.
  - 6-9: 0.
  - 10-13: 54.
  - 14-17: 40.
  - 18-21: BMP_WIDTH.
  - 22-25: BMP_HEIGHT.
  - 26-27: 1.
  - 28-29: 24.
  - 30-33: 0.
  - 34-37: IMG.
  - 38-41: PPM.
  - 42-45: PPM.
  - 46-53: 0.
  - Header emission does not depend on in_empty.
  - After byte 53 is accepted: go to PIX.
- Write handshake (combinational):
  - out_wr_en = (state in HDR/PAD, or PIX with in_empty=0) AND out_full=0.
  - out_din is valid whenever out_wr_en=1; otherwise it is 0.
  - A byte is consumed only on an edge where out_wr_en=1; the index advances on that edge only.
- PIX:
  - byte_idx 0,1,2 selects in_dout[23:16], [15:8], [7:0].
  - The pixel is not popped until its last byte is written: in_rd_en = out_wr_en AND byte_idx==2.
  - in_dout is therefore stable across the three bytes.
  - After byte 2, col increments. At col==BMP_WIDTH-1: col=0, then go to PAD if PAD!=0, else end the row.
- PAD: emits PAD bytes of 0x00, then ends the row.
- End of row: row increments. At row==BMP_HEIGHT-1 go to DONE, else PIX.
- Total bytes per frame is exactly FSZ. Total pops is exactly BMP_WIDTH*BMP_HEIGHT.
- Throughput: 1 byte/cycle with no backpressure. First header byte is written the cycle after start is sampled.
- Simultaneous events:
  - out_full=1 and in_empty=0 in PIX: no write, no pop.
  - start while busy: ignored.
  - Reset mid-frame: immediate return to IDLE; the partial stream is abandoned; the next start restarts at header byte 0.
- No combinational path from in_dout to in_rd_en.

Test Plan:
- Reset: hold reset=0 with random inputs -> out_wr_en=0, in_rd_en=0, busy=0, done=0, out_din=0.
- Header, default 720x540, out_full=0:
  - Pulse start -> 54 consecutive writes starting the next cycle.
  - Bytes 0-5 = 42 4D 76 CC 11 00.
  - Bytes 18-25 = D0 02 00 00 1C 02 00 00.
  - Bytes 34-37 = 40 CC 11 00.
  - No in_rd_en during the header.
- Pixel order and padding, BMP_WIDTH=5, BMP_HEIGHT=2, all pixels 0xAABBCC:
  - File size field = 56 00 00 00.
  - Each pixel emits AA BB CC.
  - One 0x00 after every 15 pixel bytes.
  - Total 86 bytes, 10 pops, then done=1.
- Output backpressure: assert out_full for 3 cycles when byte_idx=1 -> no out_wr_en and no in_rd_en during the hold; the stream resumes with BB, CC, then a pop; no duplicated or lost bytes.
- Input starvation: in_empty=1 for 5 cycles between pixels -> writes stall only in PIX; the header completes regardless; byte count remains FSZ.
- Reset mid-frame and restart: reset low after 100 bytes -> outputs return to 0 asynchronously; next start emits 0x42 first; start pulsed while busy has no effect on the byte sequence.

Source files
------------

// File: rtl/bmp_stream_writer.sv
// Purpose : serialises a 24-bpp BMP file (54-byte header, pixel bytes, row padding) into a byte FIFO.
// Latency : first header byte is written the cycle after start is sampled; 1 byte/cycle when unstalled.
// Backpr. : out_full stalls every state; in_empty stalls only pixel bytes; a pixel is popped with its last byte.
// Ports   : clock/reset (async active-low), start, input FIFO (in_dout/in_empty/in_rd_en),
//           output FIFO (out_din/out_full/out_wr_en), status (busy, done).
module bmp_stream_writer #(
  parameter int BMP_WIDTH  = 720,
  parameter int BMP_HEIGHT = 540,
  parameter int HDR_SIZE   = 54,
  parameter int PPM        = 2835
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] in_dout,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [7:0]  out_din,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] ROW = 32'(BMP_WIDTH) * 32'd3;
  localparam logic [31:0] PAD = (32'd4 - (ROW % 32'd4)) % 32'd4;
  localparam logic [31:0] IMG = (ROW + PAD) * 32'(BMP_HEIGHT);
  localparam logic [31:0] FSZ = 32'(HDR_SIZE) + IMG;

  localparam bit         HAS_PAD  = (PAD != 32'd0);
  localparam logic [11:0] COL_LAST = 12'(BMP_WIDTH - 1);
  localparam logic [11:0] ROW_LAST = 12'(BMP_HEIGHT - 1);
  localparam logic [5:0]  HDR_LAST = 6'(HDR_SIZE - 1);
  // Only meaningful when HAS_PAD; the PAD state is unreachable otherwise.
  localparam logic [1:0]  PAD_LAST = 2'(PAD - 32'd1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PIX  = 3'd2;
  localparam logic [2:0] S_PAD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state;
  logic [5:0]  hdr_idx;
  logic [1:0]  byte_idx;   // byte within pixel in PIX, pad byte count in PAD
  logic [11:0] col;
  logic [11:0] row;
  logic        wr_req;
  logic        row_end;

  // Each header field is a little-endian word; pick the field covering idx,
  // then the byte at (idx - field start).
  function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
    logic [31:0] v;
    logic [5:0]  base;
    logic [5:0]  off;
    v    = '0;
    base = '0;
    if      (idx < 6'd2)  begin v = 32'h0000_4D42;     base = 6'd0;  end
    else if (idx < 6'd6)  begin v = FSZ;               base = 6'd2;  end
    else if (idx < 6'd10) begin v = 32'd0;             base = 6'd6;  end
    else if (idx < 6'd14) begin v = 32'(HDR_SIZE);     base = 6'd10; end
    else if (idx < 6'd18) begin v = 32'd40;            base = 6'd14; end
    else if (idx < 6'd22) begin v = 32'(BMP_WIDTH);    base = 6'd18; end
    else if (idx < 6'd26) begin v = 32'(BMP_HEIGHT);   base = 6'd22; end
    else if (idx < 6'd28) begin v = 32'd1;             base = 6'd26; end
    else if (idx < 6'd30) begin v = 32'd24;            base = 6'd28; end
    else if (idx < 6'd34) begin v = 32'd0;             base = 6'd30; end
    else if (idx < 6'd38) begin v = IMG;               base = 6'd34; end
    else if (idx < 6'd42) begin v = 32'(PPM);          base = 6'd38; end
    else if (idx < 6'd46) begin v = 32'(PPM);          base = 6'd42; end
    else                  begin v = 32'd0;             base = 6'd46; end
    off = idx - base;
    return v[{off[1:0], 3'b000} +: 8];
  endfunction

  always_comb begin
    wr_req = 1'b0;
    case (state)
      S_HDR, S_PAD: wr_req = 1'b1;
      S_PIX:        wr_req = ~in_empty;
      default:      wr_req = 1'b0;
    endcase
    out_wr_en = wr_req & ~out_full;

    out_din = 8'h00;
    if (out_wr_en) begin
      case (state)
        S_HDR: out_din = hdr_byte(hdr_idx);
        S_PIX: begin
          case (byte_idx)
            2'd0:    out_din = in_dout[23:16];
            2'd1:    out_din = in_dout[15:8];
            default: out_din = in_dout[7:0];
          endcase
        end
        default: out_din = 8'h00;
      endcase
    end

    // Pop only with the last byte so in_dout stays put across the pixel.
    in_rd_en = out_wr_en && (state == S_PIX) && (byte_idx == 2'd2);

    row_end = out_wr_en &&
              (((state == S_PIX) && (byte_idx == 2'd2) && (col == COL_LAST) && !HAS_PAD) ||
               ((state == S_PAD) && (byte_idx == PAD_LAST)));
  end

  assign busy = (state == S_HDR) || (state == S_PIX) || (state == S_PAD);
  assign done = (state == S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      hdr_idx  <= '0;
      byte_idx <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_HDR;
            hdr_idx  <= '0;
            byte_idx <= '0;
            col      <= '0;
            row      <= '0;
          end
        end
        S_HDR: begin
          if (out_wr_en) begin
            if (hdr_idx == HDR_LAST) begin
              hdr_idx <= '0;
              state   <= S_PIX;
            end else begin
              hdr_idx <= hdr_idx + 6'd1;
            end
          end
        end
        S_PIX: begin
          if (out_wr_en) begin
            if (byte_idx == 2'd2) begin
              byte_idx <= '0;
              if (col == COL_LAST) begin
                col <= '0;
                if (HAS_PAD) state <= S_PAD;
              end else begin
                col <= col + 12'd1;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_PAD: begin
          if (out_wr_en) begin
            byte_idx <= (byte_idx == PAD_LAST) ? 2'd0 : byte_idx + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Row completion overrides the per-state next state chosen above.
      if (row_end) begin
        if (row == ROW_LAST) begin
          row   <= '0;
          state <= S_DONE;
        end else begin
          row   <= row + 12'd1;
          state <= S_PIX;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
module tb_bmp_stream_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default 720x540 (header and reset/restart only)
  logic        a_reset, a_start, a_in_empty, a_in_rd_en, a_out_full, a_out_wr_en, a_busy, a_done;
  logic [23:0] a_in_dout;
  logic [7:0]  a_out_din;
  // Instance B: 5x2, full frames
  logic        b_reset, b_start, b_in_empty, b_in_rd_en, b_out_full, b_out_wr_en, b_busy, b_done;
  logic [23:0] b_in_dout;
  logic [7:0]  b_out_din;

  bmp_stream_writer dut_a (
    .clock(clk), .reset(a_reset), .start(a_start), .in_dout(a_in_dout), .in_empty(a_in_empty),
    .in_rd_en(a_in_rd_en), .out_din(a_out_din), .out_full(a_out_full), .out_wr_en(a_out_wr_en),
    .busy(a_busy), .done(a_done)
  );

  bmp_stream_writer #(.BMP_WIDTH(5), .BMP_HEIGHT(2)) dut_b (
    .clock(clk), .reset(b_reset), .start(b_start), .in_dout(b_in_dout), .in_empty(b_in_empty),
    .in_rd_en(b_in_rd_en), .out_din(b_out_din), .out_full(b_out_full), .out_wr_en(b_out_wr_en),
    .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         pos;
    logic [7:0] exp;
  } hvec_t;

  hvec_t hv[18];
  logic [7:0] a_hdr[54];

  // 5x2 header: FSZ=86, IMG=32, PPM=0x0B13
  logic [7:0] hb[54] = '{
    8'h42, 8'h4D, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00,
    8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
    8'h01, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h20, 8'h00, 8'h00, 8'h00,
    8'h13, 8'h0B, 8'h00, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [23:0] pix(input int mode, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    if (mode == 0) return 24'hAABBCC;
    return {8'h10 + kk, 8'h20 + kk, 8'h30 + kk};
  endfunction

  // mode 0: constant pixels, no stalls; 1: out_full held 3 cycles at byte_idx=1;
  // 2: in_empty during the header and for 5 cycles between pixels 2 and 3.
  task automatic run_b(input int mode);
    logic [7:0] exp_q[$];
    bit         exp_pop[$];
    logic [23:0] p;
    int nbytes, npops, hold, stall, hdr_done_cyc;
    bit trig;
    for (int i = 0; i < 54; i++) begin exp_q.push_back(hb[i]); exp_pop.push_back(1'b0); end
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 5; c++) begin
        p = pix(mode, r * 5 + c);
        exp_q.push_back(p[23:16]); exp_pop.push_back(1'b0);
        exp_q.push_back(p[15:8]);  exp_pop.push_back(1'b0);
        exp_q.push_back(p[7:0]);   exp_pop.push_back(1'b1);
      end
      exp_q.push_back(8'h00); exp_pop.push_back(1'b0);
    end

    nbytes = 0; npops = 0; hold = 0; stall = 0; trig = 1'b0; hdr_done_cyc = -1;
    @(negedge clk);
    b_start = 1'b1; b_out_full = 1'b0; b_in_empty = (mode == 2); b_in_dout = pix(mode, 0);
    @(negedge clk);
    b_start = 1'b0;
    #1 check($sformatf("b_done_clears_m%0d", mode), {31'd0, b_done}, 32'd0);
    for (int cyc = 0; cyc < 400 && !b_done; cyc++) begin
      if (mode == 1 && !trig && nbytes == 55) begin trig = 1'b1; hold = 3; end
      if (mode == 2 && !trig && nbytes == 60) begin trig = 1'b1; stall = 5; end
      b_out_full = (hold > 0);
      b_in_empty = (mode == 2) && ((nbytes < 54) || (stall > 0));
      b_in_dout  = pix(mode, npops);
      #1;
      if (hold > 0 || stall > 0) begin
        check($sformatf("b_hold_wr_m%0d", mode), {31'd0, b_out_wr_en}, 32'd0);
        check($sformatf("b_hold_rd_m%0d", mode), {31'd0, b_in_rd_en}, 32'd0);
        if (hold > 0) hold--;
        if (stall > 0) stall--;
      end else begin
        check($sformatf("b_wr_m%0d_c%0d", mode, cyc), {31'd0, b_out_wr_en}, 32'd1);
        if (b_out_wr_en) begin
          if (nbytes < 86) begin
            check($sformatf("b_byte_m%0d_%0d", mode, nbytes), {24'd0, b_out_din}, {24'd0, exp_q[nbytes]});
            check($sformatf("b_pop_m%0d_%0d", mode, nbytes), {31'd0, b_in_rd_en}, {31'd0, exp_pop[nbytes]});
          end else begin
            check($sformatf("b_extra_byte_m%0d", mode), nbytes, 32'd85);
          end
          if (b_in_rd_en) npops++;
          nbytes++;
          if (nbytes == 54) hdr_done_cyc = cyc;
        end
      end
      @(negedge clk);
    end
    #1;
    check($sformatf("b_hdr_cycles_m%0d", mode), hdr_done_cyc, 32'd53);
    check($sformatf("b_done_m%0d", mode), {31'd0, b_done}, 32'd1);
    check($sformatf("b_busy_end_m%0d", mode), {31'd0, b_busy}, 32'd0);
    check($sformatf("b_nbytes_m%0d", mode), nbytes, 32'd86);
    check($sformatf("b_npops_m%0d", mode), npops, 32'd10);
    @(negedge clk);
    #1 check($sformatf("b_idle_wr_m%0d", mode), {31'd0, b_out_wr_en}, 32'd0);
  endtask

  initial begin
    hv[0]  = '{0,  8'h42}; hv[1]  = '{1,  8'h4D}; hv[2]  = '{2,  8'h76};
    hv[3]  = '{3,  8'hCC}; hv[4]  = '{4,  8'h11}; hv[5]  = '{5,  8'h00};
    hv[6]  = '{18, 8'hD0}; hv[7]  = '{19, 8'h02}; hv[8]  = '{20, 8'h00};
    hv[9]  = '{21, 8'h00}; hv[10] = '{22, 8'h1C}; hv[11] = '{23, 8'h02};
    hv[12] = '{24, 8'h00}; hv[13] = '{25, 8'h00}; hv[14] = '{34, 8'h40};
    hv[15] = '{35, 8'hCC}; hv[16] = '{36, 8'h11}; hv[17] = '{37, 8'h00};

    // Reset with random inputs
    a_reset = 1'b0; b_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_start = 1'($urandom); a_in_empty = 1'($urandom); a_out_full = 1'($urandom); a_in_dout = 24'($urandom);
      b_start = 1'($urandom); b_in_empty = 1'($urandom); b_out_full = 1'($urandom); b_in_dout = 24'($urandom);
      #1;
      check("rst_a_wr", {31'd0, a_out_wr_en}, 32'd0);
      check("rst_a_rd", {31'd0, a_in_rd_en}, 32'd0);
      check("rst_a_busy_done", {30'd0, a_busy, a_done}, 32'd0);
      check("rst_a_din", {24'd0, a_out_din}, 32'd0);
      check("rst_b_all", {21'd0, b_out_wr_en, b_in_rd_en, b_busy, b_done, b_out_din}, 32'd0);
    end
    @(negedge clk);
    a_start = 1'b0; a_in_empty = 1'b0; a_out_full = 1'b0; a_in_dout = 24'h123456;
    b_start = 1'b0; b_in_empty = 1'b0; b_out_full = 1'b0; b_in_dout = 24'h0;
    a_reset = 1'b1; b_reset = 1'b1;

    // Default-size header
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 54; i++) begin
      #1;
      check($sformatf("a_hdr_wr_%0d", i), {31'd0, a_out_wr_en}, 32'd1);
      check($sformatf("a_hdr_rd_%0d", i), {31'd0, a_in_rd_en}, 32'd0);
      a_hdr[i] = a_out_din;
      @(negedge clk);
    end
    for (int i = 0; i < 18; i++)
      check($sformatf("a_hdr_byte_%0d", hv[i].pos), {24'd0, a_hdr[hv[i].pos]}, {24'd0, hv[i].exp});

    // Pixel bytes up to 100 total, with a start pulse while busy
    for (int i = 54; i < 100; i++) begin
      a_start = (i == 70);
      #1;
      check($sformatf("a_pix_wr_%0d", i), {31'd0, a_out_wr_en}, 32'd1);
      case ((i - 54) % 3)
        0:       check($sformatf("a_pix_%0d", i), {24'd0, a_out_din}, 32'h12);
        1:       check($sformatf("a_pix_%0d", i), {24'd0, a_out_din}, 32'h34);
        default: check($sformatf("a_pix_%0d", i), {24'd0, a_out_din}, 32'h56);
      endcase
      check($sformatf("a_pix_rd_%0d", i), {31'd0, a_in_rd_en}, {31'd0, ((i - 54) % 3) == 2});
      @(negedge clk);
    end
    a_start = 1'b0;

    // Asynchronous reset mid-frame, then restart from header byte 0
    a_reset = 1'b0;
    #1;
    check("a_midrst_wr", {31'd0, a_out_wr_en}, 32'd0);
    check("a_midrst_rd", {31'd0, a_in_rd_en}, 32'd0);
    check("a_midrst_din", {24'd0, a_out_din}, 32'd0);
    check("a_midrst_busy_done", {30'd0, a_busy, a_done}, 32'd0);
    @(negedge clk);
    a_reset = 1'b1;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    #1;
    check("a_restart_wr", {31'd0, a_out_wr_en}, 32'd1);
    check("a_restart_b0", {24'd0, a_out_din}, 32'h42);
    @(negedge clk);
    #1 check("a_restart_b1", {24'd0, a_out_din}, 32'h4D);
    a_reset = 1'b0;

    // Small frame: order/padding, backpressure, starvation
    run_b(0);
    run_b(1);
    run_b(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
